// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_queue_pkg;
  typedef logic [31:0] word_t;

  // Buffered fetch record. The PC sits in the upper half of the packed word.
  typedef struct packed {
    word_t pc;
    word_t inst;
  } fetch_entry_t;

  localparam int unsigned PC_STEP = 4;
endpackage

// File: rtl/fetch_queue_if.sv
// Decode-side view of the fetch queue: fq drives the head entry, dp consumes it.
interface fetch_queue_if #(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned DEPTH  = 4
);
  logic                         deq;
  logic                         inst_valid;
  logic [WORD_W-1:0]            inst;
  logic [WORD_W-1:0]            inst_pc;
  logic [WORD_W-1:0]            inst_npc;
  logic [$clog2(DEPTH+1)-1:0]   count;
  logic                         full;

  modport fq (input deq, output inst_valid, inst, inst_pc, inst_npc, count, full);
  modport dp (output deq, input inst_valid, inst, inst_pc, inst_npc, count, full);
endinterface

// File: rtl/fetch_fifo.sv
// DEPTH-entry circular buffer of {pc, inst} records with push, pop, flush and occupancy.
module fetch_fifo
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 64,
  localparam int unsigned CNT_W = $clog2(DEPTH+1),
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic              i_flush,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata,
  output logic [CNT_W-1:0]  o_count
);
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_tail <= r_tail + PTR_W'(1);
      if (i_pop)  r_head <= r_head + PTR_W'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: a slot is only read once occupancy covers it.
  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_tail] <= i_wdata;
  end

  assign o_rdata = r_mem[r_head];
  assign o_count = r_count;
endmodule

// File: rtl/fetch_queue.sv
// Fetch front end: owns the fetch PC, issues sequential reads and buffers them for decode.
// Optional FETCH_BYPASS_EN forwards imemload straight to the head outputs when the queue is empty.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter              PC_INIT = 0,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned WORD_W  = 32,
  localparam int unsigned CNT_W  = $clog2(DEPTH+1)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ihit,
  input  logic [WORD_W-1:0] imemload,
  output logic              imemREN,
  output logic [WORD_W-1:0] imemaddr,
  input  logic              redirect,
  input  logic [WORD_W-1:0] redirect_pc,
  input  logic              halt,
  input  logic              deq,
  output logic              inst_valid,
  output logic [WORD_W-1:0] inst,
  output logic [WORD_W-1:0] inst_pc,
  output logic [WORD_W-1:0] inst_npc,
  output logic [CNT_W-1:0]  count,
  output logic              full
);
  logic [WORD_W-1:0]   r_fpc;
  logic                r_halted;
  logic [CNT_W-1:0]    w_count;
  logic [2*WORD_W-1:0] w_head;
  logic                w_full, w_empty, w_ren, w_fire, w_bypass, w_push, w_pop;

  assign w_full  = (w_count == CNT_W'(DEPTH));
  assign w_empty = (w_count == '0);
  assign w_ren   = !w_full && !r_halted && !RST;
  assign w_fire  = w_ren && ihit && !redirect;

`ifdef FETCH_BYPASS_EN
  assign w_bypass = w_empty && w_fire;
`else
  assign w_bypass = 1'b0;
`endif

  // A bypassed word that is consumed in the same cycle never enters storage.
  assign w_push = w_fire && !(w_bypass && deq);
  assign w_pop  = deq && !w_empty && !redirect;

  fetch_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (2*WORD_W)
  ) u_fifo (
    .clk     (CLK),
    .rst     (RST),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirect),
    .i_wdata ({r_fpc, imemload}),
    .o_rdata (w_head),
    .o_count (w_count)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_fpc    <= WORD_W'(PC_INIT);
      r_halted <= 1'b0;
    end else begin
      if (halt) r_halted <= 1'b1;
      if (redirect)    r_fpc <= {redirect_pc[WORD_W-1:2], 2'b00};
      else if (w_fire) r_fpc <= r_fpc + WORD_W'(PC_STEP);
    end
  end

  always_comb begin
    inst_valid = 1'b0;
    inst       = '0;
    inst_pc    = '0;
    inst_npc   = '0;
    if (w_bypass) begin
      inst_valid = 1'b1;
      inst       = imemload;
      inst_pc    = r_fpc;
      inst_npc   = r_fpc + WORD_W'(PC_STEP);
    end else if (!w_empty) begin
      inst_valid = 1'b1;
      inst_pc    = w_head[2*WORD_W-1:WORD_W];
      inst       = w_head[WORD_W-1:0];
      inst_npc   = w_head[2*WORD_W-1:WORD_W] + WORD_W'(PC_STEP);
    end
  end

  assign imemREN  = w_ren;
  assign imemaddr = r_fpc;
  assign count    = w_count;
  assign full     = w_full;
endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue; expected entries queue up as fetches are driven.
module tb_fetch_queue;
`ifdef FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        ihit = 1'b0, redirect = 1'b0, halt = 1'b0, deq = 1'b0;
  logic [31:0] imemload = '0, redirect_pc = '0;
  logic        imemREN, inst_valid, full;
  logic [31:0] imemaddr, inst, inst_pc, inst_npc;
  logic [2:0]  count;

  logic        ihit1 = 1'b0, deq1 = 1'b0, redirect1 = 1'b0, halt1 = 1'b0;
  logic [31:0] imemload1 = '0, redirect_pc1 = '0;
  logic        imemREN1, inst_valid1, full1;
  logic [31:0] imemaddr1, inst1, inst_pc1, inst_npc1;
  logic [2:0]  count1;

  fetch_queue #(.PC_INIT(0), .DEPTH(DEPTH), .WORD_W(32)) dut (
    .CLK(clk), .RST(rst), .ihit(ihit), .imemload(imemload), .imemREN(imemREN),
    .imemaddr(imemaddr), .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
    .deq(deq), .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .inst_npc(inst_npc), .count(count), .full(full)
  );

  fetch_queue #(.PC_INIT(32'hFFFF_FFF8), .DEPTH(DEPTH), .WORD_W(32)) dut_wrap (
    .CLK(clk), .RST(rst), .ihit(ihit1), .imemload(imemload1), .imemREN(imemREN1),
    .imemaddr(imemaddr1), .redirect(redirect1), .redirect_pc(redirect_pc1), .halt(halt1),
    .deq(deq1), .inst_valid(inst_valid1), .inst(inst1), .inst_pc(inst_pc1),
    .inst_npc(inst_npc1), .count(count1), .full(full1)
  );

  ent_t        sb[$];
  logic [31:0] m_fpc = '0;
  bit          m_halted = 1'b0;
  int          vectors = 0;
  int          miscompares = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'd7) ^ 32'h5A00_0000;
  endfunction

  function automatic bit byp_now();
    return BYP && sb.size() == 0 && !m_halted && !rst && ihit && !redirect;
  endfunction

  task automatic set_in(input bit h, input bit d, input bit r, input logic [31:0] rp, input bit hl);
    ihit = h; deq = d; redirect = r; redirect_pc = rp; halt = hl;
    imemload = mem_word(m_fpc);
    #2;
  endtask

  // Advances one clock and applies the same cycle to the reference model.
  task automatic step();
    bit   ren, fire, byp;
    int   was;
    ent_t e, gone;
    ren  = (sb.size() != DEPTH) && !m_halted && !rst;
    fire = ren && ihit && !redirect;
    byp  = byp_now();
    was  = sb.size();
    @(posedge clk);
    if (redirect) begin
      sb.delete();
      m_fpc = {redirect_pc[31:2], 2'b00};
    end else begin
      if (fire) begin
        e.pc = m_fpc; e.inst = mem_word(m_fpc);
        sb.push_back(e);
        m_fpc = m_fpc + 32'd4;
      end
      if (deq && (was != 0 || byp)) gone = sb.pop_front();
    end
    if (halt) m_halted = 1'b1;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    sb.delete(); m_fpc = '0; m_halted = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk); #3;
    vectors++; if (imemREN !== 1'b0) begin miscompares++; $display("FAIL reset_ren: got %b want 0", imemREN); end
    vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", count); end
    vectors++; if (inst_valid !== 1'b0 || full !== 1'b0) begin miscompares++; $display("FAIL reset_flags: valid %b full %b want 0 0", inst_valid, full); end
    vectors++; if ({inst, inst_pc, inst_npc} !== 96'd0) begin miscompares++; $display("FAIL reset_head: got %h %h %h want zeros", inst, inst_pc, inst_npc); end
    vectors++; if (imemaddr !== 32'h0) begin miscompares++; $display("FAIL reset_pc: got %h want 00000000", imemaddr); end
    vectors++; if (imemaddr1 !== 32'hFFFF_FFF8) begin miscompares++; $display("FAIL reset_pc_init: got %h want fffffff8", imemaddr1); end
    @(posedge clk); #1;
    rst = 1'b0;
    set_in(0, 0, 0, 32'h0, 0);
    vectors++; if (imemREN !== 1'b1) begin miscompares++; $display("FAIL first_ren: got %b want 1", imemREN); end
    step();
  endtask

  task automatic test_fill();
    for (int i = 0; i < 5; i++) begin
      set_in(1, 0, 0, 32'h0, 0);
      vectors++; if (imemaddr !== 32'(4 * (i < 4 ? i : 4))) begin miscompares++; $display("FAIL fill_addr[%0d]: got %h want %h", i, imemaddr, 32'(4 * (i < 4 ? i : 4))); end
      vectors++; if (count !== 3'(sb.size())) begin miscompares++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, count, sb.size()); end
      step();
    end
    set_in(0, 0, 0, 32'h0, 0);
    vectors++; if (full !== 1'b1 || imemREN !== 1'b0) begin miscompares++; $display("FAIL fill_full: full %b ren %b want 1 0", full, imemREN); end
    vectors++; if (count !== 3'd4) begin miscompares++; $display("FAIL fill_count_end: got %0d want 4", count); end
    vectors++; if (inst_pc !== 32'h0 || inst !== mem_word(32'h0)) begin miscompares++; $display("FAIL fill_head: pc %h inst %h want 00000000 %h", inst_pc, inst, mem_word(32'h0)); end
    step();
  endtask

  task automatic test_stream();
    logic [31:0] seq = 32'h0;
    for (int i = 0; i < 10; i++) begin
      set_in(1, 1, 0, 32'h0, 0);
      vectors++; if (inst_valid !== 1'b1 || inst_pc !== seq) begin miscompares++; $display("FAIL stream_pc[%0d]: valid %b pc %h want 1 %h", i, inst_valid, inst_pc, seq); end
      vectors++; if (inst !== sb[0].inst || inst_npc !== seq + 32'd4) begin miscompares++; $display("FAIL stream_data[%0d]: inst %h npc %h want %h %h", i, inst, inst_npc, sb[0].inst, seq + 32'd4); end
      vectors++; if (count < 3'd3 || count > 3'd4) begin miscompares++; $display("FAIL stream_count[%0d]: got %0d want 3..4", i, count); end
      seq = seq + 32'd4;
      step();
    end
  endtask

  task automatic test_redirect();
    logic [31:0] lost_pc;
    set_in(0, 1, 0, 32'h0, 0);
    step();
    set_in(1, 1, 1, 32'h0000_0103, 0);
    vectors++; if (count !== 3'd2) begin miscompares++; $display("FAIL redir_pre_count: got %0d want 2", count); end
    lost_pc = m_fpc;
    step();
    set_in(0, 0, 0, 32'h0, 0);
    vectors++; if (count !== 3'd0 || inst_valid !== 1'b0) begin miscompares++; $display("FAIL redir_flush: count %0d valid %b want 0 0", count, inst_valid); end
    vectors++; if (imemaddr !== 32'h0000_0100) begin miscompares++; $display("FAIL redir_addr: got %h want 00000100", imemaddr); end
    step();
    for (int i = 0; i < 6; i++) begin
      set_in(1, 1, 0, 32'h0, 0);
      vectors++; if (inst_valid && inst === mem_word(lost_pc)) begin miscompares++; $display("FAIL redir_lost[%0d]: got %h want anything else", i, inst); end
      if (sb.size() != 0) begin
        vectors++; if (inst_pc !== sb[0].pc) begin miscompares++; $display("FAIL redir_head[%0d]: got %h want %h", i, inst_pc, sb[0].pc); end
      end
      step();
    end
  endtask

  task automatic test_halt();
    for (int i = 0; i < 8 && sb.size() != 3; i++) begin
      set_in(1, 0, 0, 32'h0, 0);
      step();
    end
    set_in(0, 0, 0, 32'h0, 1);
    vectors++; if (count !== 3'd3) begin miscompares++; $display("FAIL halt_pre_count: got %0d want 3", count); end
    step();
    for (int i = 0; i < 3; i++) begin
      set_in(1, 1, 0, 32'h0, 0);
      vectors++; if (imemREN !== 1'b0) begin miscompares++; $display("FAIL halt_ren[%0d]: got %b want 0", i, imemREN); end
      vectors++; if (inst_valid !== 1'b1 || inst_pc !== sb[0].pc) begin miscompares++; $display("FAIL halt_drain[%0d]: valid %b pc %h want 1 %h", i, inst_valid, inst_pc, sb[0].pc); end
      step();
    end
    for (int i = 0; i < 3; i++) begin
      set_in(1, 1, 0, 32'h0, 0);
      vectors++; if (inst_valid !== 1'b0 || count !== 3'd0 || imemREN !== 1'b0) begin miscompares++; $display("FAIL halt_empty[%0d]: valid %b count %0d ren %b want 0 0 0", i, inst_valid, count, imemREN); end
      step();
    end
    set_in(1, 1, 1, 32'h0000_0200, 0);
    step();
    set_in(1, 0, 0, 32'h0, 0);
    vectors++; if (imemaddr !== 32'h0000_0200 || imemREN !== 1'b0) begin miscompares++; $display("FAIL halt_redirect: addr %h ren %b want 00000200 0", imemaddr, imemREN); end
    step();
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      set_in(1, 0, 0, 32'h0, 0);
      step();
    end
    set_in(0, 0, 0, 32'h0, 0);
    vectors++; if (count !== 3'd2) begin miscompares++; $display("FAIL areset_pre: got %0d want 2", count); end
    rst = 1'b1;
    #1;
    vectors++; if (count !== 3'd0 || inst_valid !== 1'b0 || imemaddr !== 32'h0) begin miscompares++; $display("FAIL areset_clear: count %0d valid %b addr %h want 0 0 0", count, inst_valid, imemaddr); end
    sb.delete(); m_fpc = '0; m_halted = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_bypass_latency();
    set_in(1, 1, 0, 32'h0, 0);
    vectors++; if (inst_valid !== BYP) begin miscompares++; $display("FAIL byp_valid0: got %b want %b", inst_valid, BYP); end
    if (BYP) begin
      vectors++; if (inst !== mem_word(32'h0) || inst_pc !== 32'h0) begin miscompares++; $display("FAIL byp_data: inst %h pc %h want %h 00000000", inst, inst_pc, mem_word(32'h0)); end
    end
    step();
    set_in(1, 1, 0, 32'h0, 0);
    vectors++; if (count !== (BYP ? 3'd0 : 3'd1) || inst_valid !== 1'b1) begin miscompares++; $display("FAIL byp_next: count %0d valid %b want %0d 1", count, inst_valid, BYP ? 0 : 1); end
    step();
  endtask

  task automatic test_wrap();
    logic [31:0] exp_addr [3];
    exp_addr[0] = 32'hFFFF_FFF8; exp_addr[1] = 32'hFFFF_FFFC; exp_addr[2] = 32'h0;
    for (int i = 0; i < 3; i++) begin
      ihit1 = 1'b1; deq1 = 1'b1; imemload1 = mem_word(exp_addr[i]);
      #2;
      vectors++; if (imemaddr1 !== exp_addr[i]) begin miscompares++; $display("FAIL wrap_addr[%0d]: got %h want %h", i, imemaddr1, exp_addr[i]); end
      if (i == 2) begin
        vectors++; if (inst_npc1 !== (BYP ? 32'h4 : 32'h0)) begin miscompares++; $display("FAIL wrap_npc: got %h want %h", inst_npc1, BYP ? 32'h4 : 32'h0); end
      end
      @(posedge clk); #1;
    end
    ihit1 = 1'b0; deq1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_stream();
    test_redirect();
    test_halt();
    test_async_reset();
    test_bypass_latency();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
